// File: rtl/flash_audio_pkg.sv
// flash_audio_pkg: shared state encoding and flash constants for the flash sample reader
package flash_audio_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, SAMP_LO, SAMP_HI} state_t;
  localparam logic [3:0] FLASH_BYTEENABLE = 4'hF;
  localparam int DEF_ADDR_W = 23;
  localparam logic [22:0] DEF_START_ADDR = 23'h000000;
  localparam logic [22:0] DEF_END_ADDR = 23'h07FFFF;
endpackage

// File: rtl/flash_sample_reader_if.sv
// flash_sample_reader_if: Avalon-MM read-only flash port
interface flash_sample_reader_if
  import flash_audio_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              waitrequest;
  logic [31:0]       readdata;
  logic              readdatavalid;
  modport master (output read, address, byteenable, input waitrequest, readdata, readdatavalid);
  modport slave (input read, address, byteenable, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/flash_sample_reader.sv
// flash_sample_reader: fetches 32-bit flash words and emits them as two 16-bit samples on sample_tick
module flash_sample_reader
  import flash_audio_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = DEF_START_ADDR,
  parameter logic [ADDR_W-1:0] END_ADDR   = DEF_END_ADDR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_en,
  input  logic                 sample_tick,
  flash_sample_reader_if.master flash,
  output logic [15:0]          audio_sample,
  output logic                 sample_valid,
  output logic                 read_complete
);
  state_t      state;
  logic [31:0] word;
  logic        at_end;
  logic        fire;
  assign flash.byteenable = FLASH_BYTEENABLE;
  assign at_end = flash.address == END_ADDR;
  assign fire = play_en && sample_tick;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      flash.read    <= 1'b0;
      flash.address <= START_ADDR;
      word          <= '0;
      audio_sample  <= '0;
      sample_valid  <= 1'b0;
      read_complete <= 1'b0;
    end else begin
      sample_valid  <= 1'b0;
      read_complete <= 1'b0;
      case (state)
        IDLE: if (play_en) begin
          state      <= REQ;
          flash.read <= 1'b1;
        end
        // a posted request is held until accepted, even if play_en drops
        REQ: if (!flash.waitrequest) begin
          state      <= WAIT_DATA;
          flash.read <= 1'b0;
        end
        WAIT_DATA: if (flash.readdatavalid) begin
          word  <= flash.readdata;
          state <= SAMP_LO;
        end
        SAMP_LO: if (fire) begin
          audio_sample <= word[15:0];
          sample_valid <= 1'b1;
          state        <= SAMP_HI;
        end
        SAMP_HI: if (fire) begin
          audio_sample  <= word[31:16];
          sample_valid  <= 1'b1;
          read_complete <= at_end;
          flash.address <= at_end ? START_ADDR : flash.address + 1'b1;
          state         <= REQ;
          flash.read    <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_sample_reader.sv
// tb_flash_sample_reader: directed plus randomized scoreboard bench for flash_sample_reader
module tb_flash_sample_reader;
  localparam logic [22:0] S = 23'h000100;
  localparam logic [22:0] E = 23'h000101;
  typedef struct packed {logic [15:0] s; logic rc;} exp_t;
  logic clk = 1'b0, reset = 1'b1, play_en = 1'b0, sample_tick = 1'b0;
  logic [15:0] audio_sample;
  logic sample_valid, read_complete;
  exp_t sb[$];
  int checks = 0, errors = 0, rc_count = 0, samples = 0;
  logic random_wr = 1'b0, use_fixed = 1'b1, spur = 1'b0;
  int lat_min = 2, lat_max = 2;
  logic [22:0] exp_addr = S;
  logic [31:0] fixed_data = 32'hBEEF_1234;
  flash_sample_reader_if #(.ADDR_W(23)) flash ();
  flash_sample_reader #(.ADDR_W(23), .START_ADDR(S), .END_ADDR(E)) dut (
    .clk(clk), .reset(reset), .play_en(play_en), .sample_tick(sample_tick),
    .flash(flash.master), .audio_sample(audio_sample), .sample_valid(sample_valid),
    .read_complete(read_complete)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic tick();
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
  endtask
  // flash model: every accepted read yields a word; the word's two halves are the expected samples
  initial begin
    logic acc;
    logic [22:0] acc_addr;
    logic [31:0] d, pend_data;
    int pend_cnt;
    pend_cnt = -1;
    pend_data = '0;
    flash.readdatavalid = 1'b0;
    flash.readdata = '0;
    flash.waitrequest = 1'b1;
    forever begin
      @(negedge clk);
      acc = flash.read && !flash.waitrequest && !reset;
      acc_addr = flash.address;
      @(posedge clk);
      #2;
      flash.readdatavalid = 1'b0;
      flash.readdata = $urandom;
      if (reset) pend_cnt = -1;
      else begin
        if (acc) begin
          checks++;
          if (acc_addr !== exp_addr) begin
            errors++;
            $display("FAIL req_addr: got %h expected %h", acc_addr, exp_addr);
          end
          d = use_fixed ? fixed_data : $urandom;
          sb.push_back('{s: d[15:0], rc: 1'b0});
          sb.push_back('{s: d[31:16], rc: exp_addr == E});
          exp_addr = (exp_addr == E) ? S : exp_addr + 23'd1;
          pend_data = d;
          pend_cnt = $urandom_range(lat_max, lat_min);
        end
        if (pend_cnt == 0) begin
          flash.readdatavalid = 1'b1;
          flash.readdata = pend_data;
          pend_cnt = -1;
        end else if (pend_cnt > 0) pend_cnt--;
        else if (spur) begin
          flash.readdatavalid = 1'b1;
          flash.readdata = 32'hDEAD_DEAD;
        end
        if (random_wr) flash.waitrequest = ($urandom_range(0, 2) == 0);
      end
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        checks++;
        samples++;
        if (read_complete) rc_count++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sample_unexpected: got %h expected none", audio_sample);
        end else begin
          e = sb.pop_front();
          if (audio_sample !== e.s || read_complete !== e.rc) begin
            errors++;
            $display("FAIL sample: got %h/rc=%b expected %h/rc=%b", audio_sample, read_complete, e.s, e.rc);
          end
        end
      end else if (read_complete) begin
        checks++;
        errors++;
        $display("FAIL rc_without_valid: got 1 expected 0");
      end
    end
  end
  initial begin
    int cnt;
    logic seen, done;
    cyc(3);
    chk("rst_read", flash.read, 0);
    chk("rst_addr", flash.address, S);
    chk("rst_audio", audio_sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("byteenable", flash.byteenable, 4'hF);
    reset = 1'b0;
    cyc(1);
    play_en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (!flash.read && cnt > 0) break;
      if (flash.read) cnt++;
      if (cnt == 4) flash.waitrequest = 1'b0;
    end
    chk("t2_read_cycles", cnt, 4);
    cyc(8);
    tick();
    chk("t2_lo", audio_sample, 16'h1234);
    chk("t2_lo_valid", sample_valid, 1);
    cyc(2);
    tick();
    chk("t2_hi", audio_sample, 16'hBEEF);
    chk("t2_addr", flash.address, S + 23'd1);
    cyc(8);
    tick();
    play_en = 1'b0;
    repeat (5) begin
      cyc(1);
      tick();
      chk("t3_paused", {sample_valid, audio_sample}, {1'b0, 16'h1234});
    end
    flash.waitrequest = 1'b1;
    play_en = 1'b1;
    cyc(1);
    tick();
    chk("t3_resume", audio_sample, 16'hBEEF);
    chk("t4_rc", read_complete, 1);
    cyc(1);
    chk("t4_rc_count", rc_count, 1);
    chk("t4_wrap_addr", flash.address, S);
    play_en = 1'b0;
    cnt = 0;
    repeat (5) begin
      cyc(1);
      if (flash.read) cnt++;
    end
    chk("t5_read_held", cnt, 5);
    flash.waitrequest = 1'b0;
    cyc(8);
    tick();
    chk("t5_stall", {sample_valid, audio_sample}, {1'b0, 16'hBEEF});
    play_en = 1'b1;
    cyc(1);
    tick();
    chk("t5_lo", audio_sample, 16'h1234);
    flash.waitrequest = 1'b1;
    cyc(1);
    tick();
    cyc(2);
    chk("t1_in_req", {flash.read, flash.address}, {1'b1, S + 23'd1});
    reset = 1'b1;
    play_en = 1'b0;
    sb.delete();
    exp_addr = S;
    cyc(1);
    chk("t1_read", flash.read, 0);
    chk("t1_addr", flash.address, S);
    chk("t1_audio", audio_sample, 0);
    reset = 1'b0;
    lat_min = 4;
    lat_max = 4;
    flash.waitrequest = 1'b0;
    play_en = 1'b1;
    seen = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc(1);
      if (flash.read) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    chk("t6_fetch_done", done, 1);
    tick();
    chk("t6_wait_tick", sample_valid, 0);
    cyc(8);
    spur = 1'b1;
    cyc(1);
    spur = 1'b0;
    cyc(1);
    tick();
    chk("t6_spurious_ignored", audio_sample, 16'h1234);
    random_wr = 1'b1;
    use_fixed = 1'b0;
    lat_min = 0;
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) play_en = ~play_en;
      sample_tick = ($urandom_range(0, 5) == 0);
      cyc(1);
    end
    sample_tick = 1'b0;
    play_en = 1'b0;
    cyc(10);
    chk("rand_samples_seen", samples >= 40, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
